ula_sequencer: RTL and testbench

//  Sequences one ULA operation end to end: operand-register loads, ALU settle wait, result capture into the ULA latch, and result drive onto the shared 8-bit data bus.

---
 rtl/ula_sequencer_pkg.sv | 41 ++++
 rtl/ula_sequencer_if.sv | 34 +++
 rtl/ula_sequencer_counter.sv | 27 ++
 rtl/ula_sequencer.sv | 115 +++++++++++
 tb/tb_ula_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_sequencer_pkg.sv
// Shared types and constants for the ULA operation sequencer.
// State codes, opcode names and counter sizing helper.
package ula_sequencer_pkg;

    localparam int OP_W_DEF = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_GRAB   = 3'd4;
    localparam logic [2:0] ST_REQ    = 3'd5;
    localparam logic [2:0] ST_DRIVE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD_A = ST_LOAD_A,
        S_LOAD_B = ST_LOAD_B,
        S_EXEC   = ST_EXEC,
        S_GRAB   = ST_GRAB,
        S_REQ    = ST_REQ,
        S_DRIVE  = ST_DRIVE
    } state_t;

    localparam logic [OP_W_DEF-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W_DEF-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W_DEF-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W_DEF-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W_DEF-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W_DEF-1:0] OP_NOT  = 3'd5;
    localparam logic [OP_W_DEF-1:0] OP_PASS = 3'd6;
    localparam logic [OP_W_DEF-1:0] OP_SHL  = 3'd7;

    // Counter must hold the larger of the two reload values.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ula_sequencer_if.sv
// Control-unit / datapath / arbiter signals of the ULA sequencer.
// master = sequencer side, slave = environment side.
interface ula_sequencer_if
    import ula_sequencer_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
);
    logic            start;
    logic [OP_W-1:0] opcode;
    logic            unary;
    logic            flush;
    logic            bus_gnt;
    logic            load_a;
    logic            load_b;
    logic [OP_W-1:0] ula_op;
    logic            grab;
    logic            bus_req;
    logic            store_data_bus;
    logic            busy;
    logic            done;

    modport master (
        input  start, opcode, unary, flush, bus_gnt,
        output load_a, load_b, ula_op, grab,
        output bus_req, store_data_bus, busy, done
    );

    modport slave (
        output start, opcode, unary, flush, bus_gnt,
        input  load_a, load_b, ula_op, grab,
        input  bus_req, store_data_bus, busy, done
    );

endinterface

// File: rtl/ula_sequencer_counter.sv
// Loadable down-counter with zero flag.
// Shared by the EXEC settle wait and the DRIVE hold.
module seq_counter #(
    parameter int COUNTER_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 dec,
    input  logic [COUNTER_W-1:0] load_val,
    output logic                 zero
);
    logic [COUNTER_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ula_sequencer.sv
// Sequences one ULA operation: operand loads, settle, grab, bus drive.
// Outputs are registered decodes of the next state.
module ula_sequencer
    import ula_sequencer_pkg::*;
#(
    parameter int OP_W        = OP_W_DEF,
    parameter int EXEC_CYCLES = 1,
    parameter int BUS_HOLD    = 1
) (
    input  logic            clock,
    input  logic            reset,
    ula_sequencer_if.master sif
);
    localparam int CW = cnt_width(EXEC_CYCLES, BUS_HOLD);
    localparam logic [CW-1:0] EXEC_LD = CW'(EXEC_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(BUS_HOLD - 1);

    state_t          state;
    state_t          nxt;
    logic            unary_q;
    logic [OP_W-1:0] op_q;
    logic            accept;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_zero;
    logic [CW-1:0]   cnt_val;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        if (sif.flush) begin
            nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (sif.start) nxt = S_LOAD_A;
                S_LOAD_A: nxt = unary_q ? S_EXEC : S_LOAD_B;
                S_LOAD_B: nxt = S_EXEC;
                S_EXEC:   if (cnt_zero) nxt = S_GRAB;
                S_GRAB:   nxt = S_REQ;
                S_REQ:    if (sif.bus_gnt) nxt = S_DRIVE;
                S_DRIVE: begin
                    // Grant loss wins over completion.
                    if (!sif.bus_gnt) begin
                        nxt = S_REQ;
                    end else if (cnt_zero) begin
                        nxt = S_IDLE;
                    end
                end
                default:  nxt = S_IDLE;
            endcase
        end
    end

    assign accept   = (state == S_IDLE) && sif.start && !sif.flush;
    assign cnt_load = (nxt != state) &&
                      (nxt == S_EXEC || nxt == S_DRIVE);
    assign cnt_dec  = (nxt == state) &&
                      (state == S_EXEC || state == S_DRIVE);

    always_comb begin
        cnt_val = HOLD_LD;
        unique case (1'b1)
            (nxt == S_EXEC): cnt_val = EXEC_LD;
            default:         cnt_val = HOLD_LD;
        endcase
    end

    seq_counter #(
        .COUNTER_W(CW)
    ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            unary_q            <= 1'b0;
            op_q               <= '0;
            sif.load_a         <= 1'b0;
            sif.load_b         <= 1'b0;
            sif.grab           <= 1'b0;
            sif.bus_req        <= 1'b0;
            sif.store_data_bus <= 1'b0;
            sif.busy           <= 1'b0;
            sif.done           <= 1'b0;
        end else begin
            sif.load_a         <= (nxt == S_LOAD_A);
            sif.load_b         <= (nxt == S_LOAD_B);
            sif.grab           <= (nxt == S_GRAB);
            sif.bus_req        <= (nxt == S_REQ) || (nxt == S_DRIVE);
            sif.store_data_bus <= (nxt == S_DRIVE);
            sif.busy           <= (nxt != S_IDLE);
            sif.done           <= (state == S_DRIVE) && (nxt == S_IDLE) &&
                                  !sif.flush;
            if (accept) begin
                op_q    <= sif.opcode;
                unary_q <= sif.unary;
            end
        end
    end

    assign sif.ula_op = op_q;

endmodule

// File: tb/tb_ula_sequencer.sv
// Randomized scoreboard bench for ula_sequencer.
// Per-cycle expected vectors come from a phase-level operation model.
module tb_ula_sequencer;
    import ula_sequencer_pkg::*;

    localparam int EXEC_N = 2;
    localparam int HOLD_N = 3;

    typedef struct packed {
        logic       start;
        logic [2:0] opc;
        logic       un;
        logic       flush;
        logic       gnt;
    } in_t;

    typedef struct packed {
        logic       la;
        logic       lb;
        logic [2:0] op;
        logic       gr;
        logic       rq;
        logic       sd;
        logic       bz;
        logic       dn;
    } out_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    ula_sequencer_if #(.OP_W(OP_W_DEF)) sif ();

    ula_sequencer #(
        .OP_W        (OP_W_DEF),
        .EXEC_CYCLES (EXEC_N),
        .BUS_HOLD    (HOLD_N)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sif   (sif.master)
    );

    always #5 clock = ~clock;

    in_t        in_q[$];
    out_t       exp_q[$];
    logic [2:0] m_op;
    int         k;
    int         flush_at;
    bit         aborted;
    bit         sb_go = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         slot = 0;
    in_t        di;
    out_t       me;
    out_t       ma;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t sample();
        out_t v;
        v = {sif.load_a, sif.load_b, sif.ula_op, sif.grab,
             sif.bus_req, sif.store_data_bus, sif.busy, sif.done};
        return v;
    endfunction

    // Fields: la lb grab req sdb busy done; ula_op is the model's.
    function automatic out_t mk(input bit la, input bit lb, input bit gr,
                                input bit rq, input bit sd, input bit bz,
                                input bit dn);
        out_t v;
        v = {la, lb, m_op, gr, rq, sd, bz, dn};
        return v;
    endfunction

    task automatic chk(input string nm, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s slot %0d: got %b expected %b (la lb op gr rq sd bz dn)",
                     nm, slot, a, e);
        end
    endtask

    task automatic step(input bit gnt, input out_t nxt);
        in_t i;
        if (aborted) return;
        i.start = rb();
        i.opc   = 3'($urandom);
        i.un    = rb();
        i.gnt   = gnt;
        i.flush = 1'b0;
        if (k == flush_at) begin
            i.flush = 1'b1;
            nxt     = mk(0, 0, 0, 0, 0, 0, 0);
            aborted = 1'b1;
        end
        in_q.push_back(i);
        exp_q.push_back(nxt);
        k++;
    endtask

    task automatic idle_gap();
        in_t i;
        i.start = 1'b0;
        i.opc   = 3'($urandom);
        i.un    = rb();
        i.gnt   = rb();
        i.flush = ($urandom_range(0, 3) == 0);
        in_q.push_back(i);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run_op(input bit [2:0] opc, input bit un, input int fa);
        in_t i;
        int  held;
        int  guard;
        bit  in_req;
        bit  g;
        aborted  = 1'b0;
        k        = 0;
        flush_at = fa;
        i.start  = 1'b1;
        i.opc    = opc;
        i.un     = un;
        i.gnt    = rb();
        i.flush  = 1'b0;
        if (fa == 0) begin
            i.flush = 1'b1;
            in_q.push_back(i);
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            return;
        end
        m_op = opc;
        in_q.push_back(i);
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        k = 1;
        if (un) begin
            step(rb(), mk(0, 0, 0, 0, 0, 1, 0));
        end else begin
            step(rb(), mk(0, 1, 0, 0, 0, 1, 0));
            step(rb(), mk(0, 0, 0, 0, 0, 1, 0));
        end
        for (int e = 1; e <= EXEC_N; e++) begin
            step(rb(), (e == EXEC_N) ? mk(0, 0, 1, 0, 0, 1, 0)
                                     : mk(0, 0, 0, 0, 0, 1, 0));
        end
        step(rb(), mk(0, 0, 0, 1, 0, 1, 0));
        in_req = 1'b1;
        held   = 0;
        guard  = 0;
        while (!aborted) begin
            guard++;
            if (in_req) begin
                g = (guard > 40) || ($urandom_range(0, 9) < 6);
                step(g, g ? mk(0, 0, 0, 1, 1, 1, 0) : mk(0, 0, 0, 1, 0, 1, 0));
                if (g) begin
                    in_req = 1'b0;
                    held   = 0;
                end
            end else begin
                g = (guard > 40) || ($urandom_range(0, 9) < 8);
                if (!g) begin
                    step(1'b0, mk(0, 0, 0, 1, 0, 1, 0));
                    in_req = 1'b1;
                end else begin
                    held++;
                    if (held == HOLD_N) begin
                        step(1'b1, mk(0, 0, 0, 0, 0, 0, 1));
                        break;
                    end
                    step(1'b1, mk(0, 0, 0, 1, 1, 1, 0));
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (sb_go && in_q.size() > 0) begin
                di = in_q.pop_front();
                sif.start   = di.start;
                sif.opcode  = di.opc;
                sif.unary   = di.un;
                sif.flush   = di.flush;
                sif.bus_gnt = di.gnt;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (sb_go && exp_q.size() > 0) begin
                me = exp_q.pop_front();
                ma = sample();
                chk("scoreboard", ma, me);
                checks++;
                if ($countones({ma.la, ma.lb, ma.gr, ma.sd}) > 1) begin
                    errors++;
                    $display("FAIL strobe_mutex slot %0d: got %b expected at most one strobe",
                             slot, ma);
                end
                slot++;
            end
        end
    end

    initial begin
        int w;
        int gaps;
        sif.start   = 1'b0;
        sif.opcode  = '0;
        sif.unary   = 1'b0;
        sif.flush   = 1'b0;
        sif.bus_gnt = 1'b0;
        m_op        = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_state", sample(), '0);
        reset = 1'b1;

        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        for (int n = 0; n < 80; n++) begin
            gaps = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
            repeat (gaps) idle_gap();
            run_op(3'($urandom), rb(),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 14)) : -1);
        end
        repeat (2) idle_gap();

        @(negedge clock);
        #1 sb_go = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 20000) begin
            @(posedge clock);
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clock);
        sb_go = 1'b0;

        sif.flush   = 1'b0;
        sif.bus_gnt = 1'b1;
        sif.opcode  = OP_XOR;
        sif.unary   = 1'b0;
        sif.start   = 1'b1;
        @(posedge clock);
        #1 sif.start = 1'b0;
        w = 0;
        while (!sif.store_data_bus && w < 50) begin
            @(negedge clock);
            w++;
        end
        checks++;
        if (sif.store_data_bus !== 1'b1 || sif.ula_op !== OP_XOR) begin
            errors++;
            $display("FAIL reach_drive: got sdb=%b op=%0d expected sdb=1 op=%0d",
                     sif.store_data_bus, sif.ula_op, OP_XOR);
        end
        #2 reset = 1'b0;
        #1 chk("reset_in_drive", sample(), '0);
        @(negedge clock);
        chk("reset_held", sample(), '0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_after_reset", sample(), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
